// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM states,
// opcode field values and default bus widths.
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_VALID,
    S_DATA,
    S_HALT
  } fetch_state_t;

  // True when the opcode field (top three bits) of a word matches op.
  function automatic logic opcode_is(input logic [DEF_DATA_W-1:0] word,
                                     input logic [2:0] op);
    return word[DEF_DATA_W-1 -: 3] == op;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset to zero, seeded from start_pc, loaded with a
// branch target or incremented with natural wrap-around at the top.
module fetch_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // PC update; init has priority over load, load over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (init) begin
      pc <= start_pc;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ONE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the single RAM port, presents
// fetched instructions with valid/ready, slots controller loads/stores onto
// the same port while an instruction is pending, and stops on HALT.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int         ADDR_W  = DEF_ADDR_W,
  parameter int         DATA_W  = DEF_DATA_W,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              dp_req,
  input  logic              dp_we,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_wdata,
  output logic [DATA_W-1:0] dp_rdata,
  output logic              dp_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t      state_reg, state_next;
  logic [DATA_W-1:0] instr_reg;
  logic [ADDR_W-1:0] dp_addr_reg;
  logic              dp_we_reg;
  logic              pc_init, pc_ld, pc_inc;

  fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .init     (pc_init),
    .load     (pc_ld),
    .inc      (pc_inc),
    .start_pc (start_pc),
    .target   (pc_target),
    .pc       (pc)
  );

  assign instr = instr_reg;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Instruction register and captured data-access address/direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg   <= '0;
      dp_addr_reg <= '0;
      dp_we_reg   <= 1'b0;
    end else begin
      if (state_reg == S_WAIT) instr_reg <= ram_r_data;
      if (state_reg == S_VALID && dp_req) begin
        dp_addr_reg <= dp_addr;
        dp_we_reg   <= dp_we;
      end
    end
  end

  // Next-state, RAM port drive and handshake outputs.
  always_comb begin
    state_next  = state_reg;
    ram_addr    = pc;
    ram_w_en    = 1'b0;
    ram_w_data  = '0;
    instr_valid = 1'b0;
    dp_done     = 1'b0;
    dp_rdata    = '0;
    halted      = 1'b0;
    pc_init     = 1'b0;
    pc_ld       = 1'b0;
    pc_inc      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        pc_init    = 1'b1;
        state_next = S_ADDR;
      end
      S_ADDR: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        pc_inc     = 1'b1;
        state_next = opcode_is(ram_r_data, HALT_OP) ? S_HALT : S_VALID;
      end
      S_VALID: begin
        instr_valid = 1'b1;
        // A data access takes the port even if the controller is also ready;
        // the pending instruction stays put and must be consumed later.
        if (dp_req) begin
          ram_addr   = dp_addr;
          ram_w_en   = dp_we;
          ram_w_data = dp_wdata;
          state_next = S_DATA;
        end else if (instr_ready) begin
          pc_ld      = pc_load;
          state_next = S_ADDR;
        end
      end
      S_DATA: begin
        ram_addr    = dp_addr_reg;
        instr_valid = 1'b1;
        dp_done     = 1'b1;
        if (!dp_we_reg) dp_rdata = ram_r_data;
        state_next  = S_VALID;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// mix of fetches, branches, loads and stores checked against a
// transaction-level model (shadow memory + expected PC/instruction).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  start_pc;
  logic [7:0]  ram_addr;
  logic        ram_w_en;
  logic [15:0] ram_w_data;
  logic [15:0] ram_r_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        dp_req;
  logic        dp_we;
  logic [7:0]  dp_addr;
  logic [15:0] dp_wdata;
  logic [15:0] dp_rdata;
  logic        dp_done;
  logic [7:0]  pc;
  logic        halted;

  int checks = 0;
  int passed = 0;

  // Reference model: shadow memory, expected PC and current instruction.
  logic [15:0] ram     [0:255];
  logic [15:0] ref_mem [0:255];
  logic [7:0]  exp_pc;
  logic [15:0] exp_instr;

  always #5 clk = ~clk;

  // Environment RAM: synchronous, read-before-write, one-cycle latency.
  always @(posedge clk) begin
    if (ram_w_en) ram[ram_addr] <= ram_w_data;
    ram_r_data <= ram[ram_addr];
  end

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_pc    (start_pc),
    .ram_addr    (ram_addr),
    .ram_w_en    (ram_w_en),
    .ram_w_data  (ram_w_data),
    .ram_r_data  (ram_r_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .dp_req      (dp_req),
    .dp_we       (dp_we),
    .dp_addr     (dp_addr),
    .dp_wdata    (dp_wdata),
    .dp_rdata    (dp_rdata),
    .dp_done     (dp_done),
    .pc          (pc),
    .halted      (halted)
  );

  task automatic put(input logic [7:0] a, input logic [15:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  function automatic logic [15:0] non_halt(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (r[15:13] == 3'b111) r[15] = 1'b0;
    return r;
  endfunction

  // Model of one fetch: the word at the PC becomes the instruction, PC advances.
  task automatic model_fetch;
    exp_instr = ref_mem[exp_pc];
    exp_pc    = exp_pc + 8'd1;
  endtask

  task automatic idle_inputs;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    pc_target   = 8'h00;
    dp_req      = 1'b0;
    dp_we       = 1'b0;
    dp_addr     = 8'h00;
    dp_wdata    = 16'h0000;
  endtask

  task automatic do_reset(input logic [7:0] spc);
    idle_inputs();
    rst      = 1'b1;
    start_pc = spc;
    exp_pc   = spc;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Waits (bounded) for an instruction or halt; n = edges waited.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!instr_valid && !halted && n < 20);
    if (!instr_valid && !halted) begin
      checks++;
      $display("FAIL wait_valid: no valid/halt after %0d cycles (valid=%0b halted=%0b)", n, instr_valid, halted);
    end
  endtask

  // Handshake the pending instruction, optionally with a taken branch.
  task automatic consume(input logic ld, input logic [7:0] tgt);
    instr_ready = 1'b1;
    pc_load     = ld;
    pc_target   = tgt;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    if (ld) exp_pc = tgt;
  endtask

  task automatic test_reset;
    idle_inputs();
    start_pc = 8'h5A;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({pc, instr, instr_valid, dp_done, halted, ram_w_en, ram_addr, ram_w_data} !==
        {8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000}) begin
      $display("FAIL reset: pc=%h instr=%h valid=%0b done=%0b halted=%0b w_en=%0b addr=%h wdata=%h required all zero",
               pc, instr, instr_valid, dp_done, halted, ram_w_en, ram_addr, ram_w_data);
    end else passed++;
    rst = 1'b0;
    $display("txn reset");
  endtask

  task automatic test_first_fetch;
    int n;
    put(8'h00, 16'hD205);
    put(8'h01, 16'hD307);
    do_reset(8'h00);
    wait_valid(n);
    model_fetch();
    checks++;
    if (n !== 3) $display("FAIL first_latency: got %0d edges, required 3", n);
    else passed++;
    checks++;
    if (instr !== exp_instr || pc !== exp_pc)
      $display("FAIL first_fetch: instr=%h pc=%h required instr=%h pc=%h", instr, pc, exp_instr, exp_pc);
    else passed++;
    $display("txn fetch instr=%h pc=%h", instr, pc);
    consume(1'b0, 8'h00);
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL valid_drop: instr_valid=%0b required 0", instr_valid);
    else passed++;
    wait_valid(n);
    model_fetch();
    checks++;
    if (n !== 2) $display("FAIL b2b_latency: got %0d extra edges, required 2", n);
    else passed++;
    checks++;
    if (instr !== exp_instr || pc !== exp_pc)
      $display("FAIL second_fetch: instr=%h pc=%h required instr=%h pc=%h", instr, pc, exp_instr, exp_pc);
    else passed++;
    $display("txn fetch instr=%h pc=%h", instr, pc);
  endtask

  task automatic test_halt;
    int n;
    put(8'h05, 16'hE000);
    do_reset(8'h05);
    wait_valid(n);
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 8'h06)
      $display("FAIL halt_entry: halted=%0b valid=%0b pc=%h required 1 0 06", halted, instr_valid, pc);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      instr_ready = 1'($urandom);
      dp_req      = 1'($urandom);
      dp_we       = 1'b1;
      pc_load     = 1'($urandom);
      pc_target   = 8'($urandom);
      dp_addr     = 8'($urandom);
      #1;
      checks++;
      if ({halted, instr_valid, ram_w_en, dp_done, pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h06})
        $display("FAIL halt_hold[%0d]: halted=%0b valid=%0b w_en=%0b done=%0b pc=%h required 1 0 0 0 06",
                 i, halted, instr_valid, ram_w_en, dp_done, pc);
      else passed++;
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("txn halt held 20 cycles");
  endtask

  task automatic test_store_load;
    int n;
    put(8'h10, 16'hD205);
    do_reset(8'h10);
    wait_valid(n);
    model_fetch();
    dp_req = 1'b1; dp_we = 1'b1; dp_addr = 8'h40; dp_wdata = 16'hBEEF;
    #1;
    checks++;
    if (ram_w_en !== 1'b1 || ram_addr !== 8'h40 || ram_w_data !== 16'hBEEF)
      $display("FAIL store_drive: w_en=%0b addr=%h wdata=%h required 1 40 beef", ram_w_en, ram_addr, ram_w_data);
    else passed++;
    @(posedge clk); #1;
    dp_req = 1'b0;
    ref_mem[8'h40] = 16'hBEEF;
    checks++;
    if (ram_w_en !== 1'b0 || dp_done !== 1'b1 || instr !== exp_instr || instr_valid !== 1'b1)
      $display("FAIL store_done: w_en=%0b done=%0b instr=%h valid=%0b required 0 1 %h 1",
               ram_w_en, dp_done, instr, instr_valid, exp_instr);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (dp_done !== 1'b0 || instr_valid !== 1'b1)
      $display("FAIL store_pulse: done=%0b valid=%0b required 0 1", dp_done, instr_valid);
    else passed++;
    $display("txn store addr=40 data=beef");
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 8'h40;
    @(posedge clk); #1;
    dp_req = 1'b0;
    checks++;
    if (dp_done !== 1'b1 || dp_rdata !== ref_mem[8'h40])
      $display("FAIL load_data: done=%0b rdata=%h required 1 %h", dp_done, dp_rdata, ref_mem[8'h40]);
    else passed++;
    $display("txn load addr=40 data=%h", dp_rdata);
    @(posedge clk); #1;
  endtask

  task automatic test_branch;
    int n;
    put(8'h20, 16'hA123);
    consume(1'b1, 8'h20);
    checks++;
    if (ram_addr !== 8'h20) $display("FAIL branch_addr: ram_addr=%h required 20", ram_addr);
    else passed++;
    wait_valid(n);
    model_fetch();
    checks++;
    if (instr !== exp_instr || pc !== 8'h21)
      $display("FAIL branch_fetch: instr=%h pc=%h required instr=%h pc=21", instr, pc, exp_instr);
    else passed++;
    $display("txn branch target=20 instr=%h", instr);
  endtask

  task automatic test_wrap;
    int n;
    put(8'hFF, 16'h6011);
    put(8'h00, 16'hD205);
    do_reset(8'hFF);
    wait_valid(n);
    model_fetch();
    checks++;
    if (pc !== 8'h00 || instr !== exp_instr)
      $display("FAIL wrap_pc: pc=%h instr=%h required pc=00 instr=%h", pc, instr, exp_instr);
    else passed++;
    consume(1'b0, 8'h00);
    checks++;
    if (ram_addr !== 8'h00) $display("FAIL wrap_addr: ram_addr=%h required 00", ram_addr);
    else passed++;
    wait_valid(n);
    model_fetch();
    $display("txn wrap pc=%h", pc);
  endtask

  task automatic test_collision_reset;
    int n;
    logic [7:0] pc_before;
    put(8'h30, 16'hD205);
    put(8'h77, 16'h1234);
    do_reset(8'h30);
    wait_valid(n);
    model_fetch();
    pc_before = exp_pc;
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 8'h77; instr_ready = 1'b1; pc_load = 1'b1; pc_target = 8'h99;
    @(posedge clk); #1;
    dp_req = 1'b0; pc_load = 1'b0;
    checks++;
    if (dp_done !== 1'b1 || dp_rdata !== ref_mem[8'h77] || instr !== exp_instr || pc !== pc_before)
      $display("FAIL collision: done=%0b rdata=%h instr=%h pc=%h required 1 %h %h %h",
               dp_done, dp_rdata, instr, pc, ref_mem[8'h77], exp_instr, pc_before);
    else passed++;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc !== pc_before)
      $display("FAIL collision_hold: valid=%0b pc=%h required 1 %h", instr_valid, pc, pc_before);
    else passed++;
    $display("txn collision data-first");
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 8'h77;
    @(posedge clk); #1;
    dp_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({pc, instr, instr_valid, dp_done, halted, ram_w_en, ram_addr} !==
        {8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_in_data: pc=%h instr=%h valid=%0b done=%0b halted=%0b w_en=%0b addr=%h required zeros",
               pc, instr, instr_valid, dp_done, halted, ram_w_en, ram_addr);
    else passed++;
    rst = 1'b0;
    $display("txn reset during data access");
  endtask

  task automatic test_random;
    int n;
    logic [7:0]  a;
    logic [15:0] d;
    logic        ld;
    for (int i = 0; i < 256; i++) put(8'(i), non_halt(16'($urandom)));
    do_reset(8'($urandom));
    wait_valid(n);
    model_fetch();
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          ld = 1'($urandom);
          consume(ld, 8'($urandom));
          wait_valid(n);
          model_fetch();
          checks++;
          if (instr !== exp_instr || pc !== exp_pc || instr_valid !== 1'b1)
            $display("FAIL rnd_fetch[%0d]: instr=%h pc=%h valid=%0b required %h %h 1",
                     t, instr, pc, instr_valid, exp_instr, exp_pc);
          else passed++;
          $display("txn rnd fetch branch=%0b instr=%h pc=%h", ld, instr, pc);
        end
        1: begin
          a = 8'($urandom);
          d = non_halt(16'($urandom));
          dp_req = 1'b1; dp_we = 1'b1; dp_addr = a; dp_wdata = d; instr_ready = 1'($urandom);
          @(posedge clk); #1;
          dp_req = 1'b0; instr_ready = 1'b0;
          ref_mem[a] = d;
          checks++;
          if (dp_done !== 1'b1 || instr !== exp_instr || ram_w_en !== 1'b0)
            $display("FAIL rnd_store[%0d]: done=%0b instr=%h w_en=%0b required 1 %h 0",
                     t, dp_done, instr, ram_w_en, exp_instr);
          else passed++;
          @(posedge clk); #1;
          $display("txn rnd store addr=%h data=%h", a, d);
        end
        default: begin
          a = 8'($urandom);
          dp_req = 1'b1; dp_we = 1'b0; dp_addr = a;
          @(posedge clk); #1;
          dp_req = 1'b0;
          checks++;
          if (dp_done !== 1'b1 || dp_rdata !== ref_mem[a])
            $display("FAIL rnd_load[%0d]: done=%0b rdata=%h required 1 %h", t, dp_done, dp_rdata, ref_mem[a]);
          else passed++;
          @(posedge clk); #1;
          $display("txn rnd load addr=%h data=%h", a, ref_mem[a]);
        end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    start_pc = 8'h00;
    idle_inputs();
    for (int i = 0; i < 256; i++) put(8'(i), 16'h0000);
    #2;
    test_reset();
    test_first_fetch();
    test_halt();
    test_store_load();
    test_branch();
    test_wrap();
    test_collision_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
